// File: rtl/ysyx_22050039_pkg.sv
// rtl/ysyx_22050039_pkg.sv - shared widths, state encoding, op-flag positions and word helpers
package ysyx_22050039_pkg;

    localparam int XLEN  = 64;
    localparam int WLEN  = 32;
    localparam int CNT_W = 7;

    // Op-flag bit positions, shared with the decode-side key/data selector
    localparam int OP_SIGNED_BIT = 0;
    localparam int OP_REM_BIT    = 1;
    localparam int OP_WORD_BIT   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic logic [XLEN-1:0] sext_word(input logic [WLEN-1:0] x);
        return {{(XLEN-WLEN){x[WLEN-1]}}, x};
    endfunction

    function automatic logic [XLEN-1:0] zext_word(input logic [WLEN-1:0] x);
        return {{(XLEN-WLEN){1'b0}}, x};
    endfunction

endpackage

// File: rtl/ysyx_22050039_div_step.sv
// rtl/ysyx_22050039_div_step.sv - one combinational radix-2 restoring division step
module ysyx_22050039_div_step
    import ysyx_22050039_pkg::*;
#(
    parameter int W = XLEN
)
(
    input  logic [W-1:0] rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);

    logic [W:0] partial;

    // Shift the next dividend bit in, then subtract if the (W+1)-bit partial covers the divisor
    always_comb begin
        partial = {rem_i, bit_i};
        q_o     = (partial >= {1'b0, divisor_i});
        rem_o   = q_o ? (partial[W-1:0] - divisor_i) : partial[W-1:0];
    end

endmodule

// File: rtl/ysyx_22050039_divider.sv
// rtl/ysyx_22050039_divider.sv - multi-cycle RV64M iterative divider (DIV/REM, unsigned and word forms)
module ysyx_22050039_divider
    import ysyx_22050039_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            is_signed,
    input  logic            is_rem,
    input  logic            is_word,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   rem_q, dq_q, dvs_q, result_q;
    logic              sign_a_q, sign_b_q, rem_op_q, word_op_q;

    logic [XLEN-1:0]   a_ext, b_ext, a_abs, b_abs, min_neg, spec_res;
    logic              a_neg, b_neg, div_zero, ovf, special, accept, last_step;
    logic [XLEN-1:0]   step_rem, q_raw, q_sgn, r_sgn, sel_res, fin_res;
    logic              step_q;

    // Operand conditioning at accept: width select, extension, sign split and special-case detection
    always_comb begin
        a_ext = dividend;
        b_ext = divisor;
        if (is_word) begin
            a_ext = is_signed ? sext_word(dividend[WLEN-1:0]) : zext_word(dividend[WLEN-1:0]);
            b_ext = is_signed ? sext_word(divisor[WLEN-1:0])  : zext_word(divisor[WLEN-1:0]);
        end
        a_neg    = is_signed & a_ext[XLEN-1];
        b_neg    = is_signed & b_ext[XLEN-1];
        a_abs    = a_neg ? (~a_ext + 1'b1) : a_ext;
        b_abs    = b_neg ? (~b_ext + 1'b1) : b_ext;
        min_neg  = is_word ? {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}}
                           : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = (b_ext == '0);
        ovf      = is_signed && (a_ext == min_neg) && (b_ext == '1);
        special  = div_zero | ovf;
        if (div_zero) begin
            spec_res = is_rem ? (is_word ? sext_word(dividend[WLEN-1:0]) : dividend) : '1;
        end else begin
            spec_res = is_rem ? '0 : a_ext;
        end
    end

    ysyx_22050039_div_step #(.W(XLEN)) u_step (
        .rem_i     (rem_q),
        .bit_i     (dq_q[XLEN-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    // Sign fix-up and word sign-extension of the final step's outcome
    always_comb begin
        q_raw   = {dq_q[XLEN-2:0], step_q};
        q_sgn   = (sign_a_q ^ sign_b_q) ? (~q_raw + 1'b1) : q_raw;
        r_sgn   = sign_a_q ? (~step_rem + 1'b1) : step_rem;
        sel_res = rem_op_q ? r_sgn : q_sgn;
        fin_res = word_op_q ? sext_word(sel_res[WLEN-1:0]) : sel_res;
    end

    assign last_step = (cnt_q == (word_op_q ? CNT_W'(WLEN-1) : CNT_W'(XLEN-1)));
    assign accept    = in_valid && (state_q == IDLE) && !flush;
    assign result    = result_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and handshake outputs; flush overrides every transition
    always_comb begin
        state_d   = state_q;
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        case (state_q)
            IDLE:    if (accept) state_d = special ? DONE : CALC;
            CALC:    if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Datapath: capture on accept, iterate in CALC, latch the result on the way into DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            dq_q      <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            rem_op_q  <= 1'b0;
            word_op_q <= 1'b0;
        end else if (flush) begin
            cnt_q <= '0;
            rem_q <= '0;
        end else if (accept) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            dq_q      <= is_word ? {a_abs[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : a_abs;
            dvs_q     <= b_abs;
            sign_a_q  <= a_neg;
            sign_b_q  <= b_neg;
            rem_op_q  <= is_rem;
            word_op_q <= is_word;
            if (special) result_q <= spec_res;
        end else if (state_q == CALC) begin
            cnt_q <= cnt_q + 1'b1;
            rem_q <= step_rem;
            dq_q  <= q_raw;
            if (last_step) result_q <= fin_res;
        end
    end

endmodule

// File: tb/tb_ysyx_22050039_divider.sv
// tb/tb_ysyx_22050039_divider.sv - self-checking bench for ysyx_22050039_divider
module tb_ysyx_22050039_divider;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, is_signed, is_rem, is_word, flush, out_valid, out_ready;
    logic [63:0] dividend, divisor, result;
    int          checks = 0;
    int          failures = 0;

    ysyx_22050039_divider dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .is_signed (is_signed),
        .is_rem    (is_rem),
        .is_word   (is_word),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_special(input logic [63:0] a, b, input logic s, w);
        if (w) return (b[31:0] == 32'h0) || (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 64'h0) || (s && a == 64'h8000_0000_0000_0000 && b == '1);
    endfunction

    // Reference: RISC-V M-extension semantics written with native arithmetic
    function automatic logic [63:0] ref_model(input logic [63:0] a, b, input logic s, r, w);
        logic [31:0]        a32, b32, res32;
        logic signed [31:0] sa32, sb32;
        logic signed [63:0] sa, sb;
        if (w) begin
            a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
            if (b32 == 0)                                          res32 = r ? a32 : 32'hFFFF_FFFF;
            else if (s && a32 == 32'h8000_0000 && b32 == '1)       res32 = r ? 32'h0 : a32;
            else if (s)                                            res32 = r ? sa32 % sb32 : sa32 / sb32;
            else                                                   res32 = r ? a32 % b32 : a32 / b32;
            return {{32{res32[31]}}, res32};
        end
        sa = a; sb = b;
        if (b == 0)                                                return r ? a : '1;
        if (s && a == 64'h8000_0000_0000_0000 && b == '1)          return r ? 64'h0 : a;
        if (s)                                                     return r ? sa % sb : sa / sb;
        return r ? a % b : a / b;
    endfunction

    // Issue one op with out_ready high; check the cycle out_valid rises (accept cycle = 0) and the result
    task automatic run_op(input string tag, input logic [63:0] a, b, input logic s, r, w,
                          input logic [63:0] exp, input int exp_cyc);
        int cyc;
        @(negedge clk);
        dividend = a; divisor = b; is_signed = s; is_rem = r; is_word = w; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "/valid"}, 64'(out_valid), 64'd1);
        chk({tag, "/lat"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, "/res"}, result, exp);
        @(posedge clk); #1;
        chk({tag, "/idle"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] a, b, held;
        logic        s, r, w;
        int          seen, cyc;

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        is_signed = 1'b0; is_rem = 1'b0; is_word = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/in_ready", 64'(in_ready), 64'd1);
        chk("reset/out_valid", 64'(out_valid), 64'd0);
        chk("reset/result", result, 64'd0);
        @(negedge clk); rst = 1'b0;

        run_op("divu_100_7", 64'd100, 64'd7, 0, 0, 0, 64'd14, 65);
        run_op("remu_100_7", 64'd100, 64'd7, 0, 1, 0, 64'd2, 65);
        run_op("div_m7_2",   -64'sd7, 64'd2, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        run_op("rem_m7_2",   -64'sd7, 64'd2, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run_op("rem_7_m2",   64'd7, -64'sd2, 1, 1, 0, 64'd1, 65);
        run_op("divu_5_0",   64'd5, 64'd0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("remu_5_0",   64'd5, 64'd0, 0, 1, 0, 64'd5, 1);
        run_op("divw_5_0",   64'd5, 64'd0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("div_ovf",    64'h8000_0000_0000_0000, '1, 1, 0, 0, 64'h8000_0000_0000_0000, 1);
        run_op("rem_ovf",    64'h8000_0000_0000_0000, '1, 1, 1, 0, 64'd0, 1);
        run_op("divw_ovf",   64'h1_8000_0000, 64'hFFFF_FFFF, 1, 0, 1, 64'hFFFF_FFFF_8000_0000, 1);
        run_op("divuw_ff_1", 64'hFFFF_FFFF, 64'd1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        run_op("remw_9_4",   64'h0000_0003_0000_0009, 64'd4, 1, 1, 1, 64'd1, 33);

        // Back-pressure: result and handshakes frozen while out_ready is low
        @(negedge clk);
        out_ready = 1'b0;
        dividend = 64'd100; divisor = 64'd7; is_signed = 0; is_rem = 0; is_word = 0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("bp/valid", 64'(out_valid), 64'd1);
        held = result;
        chk("bp/result", held, 64'd14);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp/hold_result", result, 64'd14);
            chk("bp/hold_valid", 64'(out_valid), 64'd1);
            chk("bp/hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp/release_in_ready", 64'(in_ready), 64'd1);
        chk("bp/release_valid", 64'(out_valid), 64'd0);

        // Flush at CALC step 20
        @(negedge clk);
        dividend = 64'd1000; divisor = 64'd3; is_signed = 1; is_rem = 0; is_word = 0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush/out_valid", 64'(out_valid), 64'd0);
        chk("flush/in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("flush/no_result", 64'(seen), 64'd0);

        // Flush together with in_valid in IDLE: nothing accepted
        @(negedge clk);
        dividend = 64'd9; divisor = 64'd0; is_signed = 0; is_rem = 0; is_word = 0;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle/out_valid", 64'(out_valid), 64'd0);
        chk("flush_idle/in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk("flush_idle/still_idle", 64'(out_valid), 64'd0);

        // Reset mid-CALC
        run_op("pre_rst", 64'd77, 64'd5, 0, 0, 0, 64'd15, 65);
        @(negedge clk);
        dividend = 64'd100; divisor = 64'd7; is_signed = 0; is_rem = 0; is_word = 0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid/in_ready", 64'(in_ready), 64'd1);
        chk("rst_mid/out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid/result", result, 64'd0);
        @(negedge clk); rst = 1'b0;

        // Randomized ops against the reference model
        for (int i = 0; i < 48; i++) begin
            a = {$urandom(), $urandom()};
            s = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: b = 64'd0;
                1: begin
                    b = '1;
                    if ($urandom_range(0, 1) == 1)
                        a = w ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
                end
                2: begin
                    b = 64'($urandom_range(1, 15));
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
                3: b = {32'h0, $urandom()};
                default: b = {$urandom(), $urandom()} >> $urandom_range(0, 63);
            endcase
            run_op($sformatf("rand%0d", i), a, b, s, r, w, ref_model(a, b, s, r, w),
                   is_special(a, b, s, w) ? 1 : (w ? 33 : 65));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
